// File: rtl/uart_rx_game_start.sv
// rtl/uart_rx_game_start.sv - 8N1 UART receiver that strobes game start on a command byte
module uart_rx_game_start #(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [7:0]  START_CHAR   = 8'h53
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Game_Start,
  output logic       o_Frame_Error
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP, S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync_q, rx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d, gs_q, gs_d, fe_q, fe_d;

  logic cnt_half, cnt_last;
  assign cnt_half = (cnt_q == HALF);
  assign cnt_last = (cnt_q == LAST);

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_q <= 1'b1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= i_RX_Serial;
      rx_q   <= sync_q;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!rx_q) state_d = S_START;
      S_START:   if (cnt_half) state_d = rx_q ? S_IDLE : S_DATA;
      S_DATA:    if (cnt_last && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:    if (cnt_last) state_d = rx_q ? S_CLEANUP : S_BREAK;
      S_CLEANUP: state_d = S_IDLE;
      S_BREAK:   if (rx_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    gs_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      S_START: begin
        if (cnt_half) begin
          cnt_d = '0;
          idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_q;
          if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (rx_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
            gs_d   = (shift_q == START_CHAR);
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      dv_q    <= 1'b0;
      gs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      gs_q    <= gs_d;
      fe_q    <= fe_d;
    end
  end

  assign o_RX_DV       = dv_q;
  assign o_RX_Byte     = byte_q;
  assign o_Game_Start  = gs_q;
  assign o_Frame_Error = fe_q;

endmodule

// File: tb/tb_uart_rx_game_start.sv
// tb/tb_uart_rx_game_start.sv - scoreboard bench for uart_rx_game_start
module tb_uart_rx_game_start;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rx0, rx1;
  logic       dv0, dv1, gs0, gs1, fe0, fe1;
  logic [7:0] byte0, byte1;

  uart_rx_game_start u_dut (
    .i_Clk(clk), .i_Reset(rst0), .i_RX_Serial(rx0),
    .o_RX_DV(dv0), .o_RX_Byte(byte0), .o_Game_Start(gs0), .o_Frame_Error(fe0)
  );

  uart_rx_game_start #(.CLKS_PER_BIT(4), .START_CHAR(8'h00)) u_dut4 (
    .i_Clk(clk), .i_Reset(rst1), .i_RX_Serial(rx1),
    .o_RX_DV(dv1), .o_RX_Byte(byte1), .o_Game_Start(gs1), .o_Frame_Error(fe1)
  );

  typedef struct {
    logic [7:0]  data;
    logic        gs;
    logic        fe;
    int unsigned cyc;
  } ev_t;

  ev_t         q0[$];
  ev_t         q1[$];
  logic [7:0]  lastb[2];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb_of(input int id);
    return (id == 0) ? 217 : 4;
  endfunction

  function automatic logic [7:0] start_char_of(input int id);
    return (id == 0) ? 8'h53 : 8'h00;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int id, input logic v);
    if (id == 0) rx0 = v;
    else         rx1 = v;
  endtask

  // Reference: a framed byte surfaces 4+H+9*CPB cycles after its start edge
  // (2 synchronizer cycles plus the receiver's own t0-relative latency).
  task automatic send(input int id, input logic [7:0] data, input bit stop_ok);
    int  cpb;
    ev_t e;
    cpb    = cpb_of(id);
    e.fe   = !stop_ok;
    e.data = stop_ok ? data : lastb[id];
    e.gs   = stop_ok && (data == start_char_of(id));
    e.cyc  = cyc + 4 + (cpb - 1) / 2 + 9 * cpb;
    if (stop_ok) lastb[id] = data;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    drive_line(id, 1'b0);
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      drive_line(id, data[i]);
      wait_cycles(cpb);
    end
    drive_line(id, stop_ok);
    wait_cycles(cpb);
  endtask

  task automatic check_port(input int id, input logic dv, input logic gs, input logic fe,
                            input logic [7:0] data);
    ev_t e;
    bit  have;
    have = 1'b0;
    if (id == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
    if (id == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
    if (gs && !dv) begin
      miscompares++;
      $display("FAIL gs_without_dv port%0d cyc=%0d", id, cyc);
    end
    if (have && e.cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_event port%0d cyc=%0d: no pulse seen, required at cyc=%0d byte=%02h fe=%0b",
               id, cyc, e.cyc, e.data, e.fe);
      if (id == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
    end else if (dv || fe) begin
      vectors++;
      if (!have) begin
        miscompares++;
        $display("FAIL unexpected_pulse port%0d cyc=%0d: dv=%0b fe=%0b byte=%02h, required none",
                 id, cyc, dv, fe, data);
      end else begin
        if (e.cyc != cyc || dv !== !e.fe || fe !== e.fe || gs !== e.gs || data !== e.data) begin
          miscompares++;
          $display("FAIL event port%0d: got cyc=%0d dv=%0b gs=%0b fe=%0b byte=%02h, required cyc=%0d dv=%0b gs=%0b fe=%0b byte=%02h",
                   id, cyc, dv, gs, fe, data, e.cyc, !e.fe, e.gs, e.fe, e.data);
        end
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    check_port(0, dv0, gs0, fe0, byte0);
    check_port(1, dv1, gs1, fe1, byte1);
  end

  task automatic check_idle_outputs(input string name, input logic dv, input logic gs,
                                    input logic fe, input logic [7:0] data);
    vectors++;
    if (dv !== 1'b0 || gs !== 1'b0 || fe !== 1'b0 || data !== 8'h00) begin
      miscompares++;
      $display("FAIL %s: dv=%0b gs=%0b fe=%0b byte=%02h, required all zero", name, dv, gs, fe, data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst0 = 1'b1; rst1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    lastb[0] = 8'h00; lastb[1] = 8'h00;
    wait_cycles(3);
    check_idle_outputs("reset_port0", dv0, gs0, fe0, byte0);
    check_idle_outputs("reset_port1", dv1, gs1, fe1, byte1);
    rst0 = 1'b0; rst1 = 1'b0;
    wait_cycles(5);

    send(0, 8'h53, 1'b1);
    wait_cycles(20);
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b1);
    wait_cycles(20);

    // Bad stop bit, then line held in break.
    send(0, 8'h53, 1'b0);
    wait_cycles(5000);
    drive_line(0, 1'b1);
    wait_cycles(2 * 217);
    send(0, 8'h01, 1'b1);
    wait_cycles(20);

    drive_line(0, 1'b0);
    wait_cycles(50);
    drive_line(0, 1'b1);
    wait_cycles(300);
    send(0, 8'h53, 1'b1);
    wait_cycles(20);

    // Reset pulse in the middle of data bit 4 of 0x53; the sender aborts.
    b = 8'h53;
    drive_line(0, 1'b0);
    wait_cycles(217);
    for (int i = 0; i < 4; i++) begin
      drive_line(0, b[i]);
      wait_cycles(217);
    end
    drive_line(0, b[4]);
    wait_cycles(100);
    rst0 = 1'b1;
    wait_cycles(1);
    rst0 = 1'b0;
    lastb[0] = 8'h00;
    check_idle_outputs("midframe_reset", dv0, gs0, fe0, byte0);
    drive_line(0, 1'b1);
    wait_cycles(3 * 217);
    send(0, 8'h53, 1'b1);

    for (int n = 0; n < 4; n++) begin
      wait_cycles($urandom_range(0, 300));
      send(0, ($urandom_range(0, 3) == 0) ? 8'h53 : 8'($urandom), 1'b1);
    end

    send(1, 8'h00, 1'b1);
    send(1, 8'hFF, 1'b1);
    for (int n = 0; n < 40; n++) begin
      wait_cycles($urandom_range(0, 12));
      send(1, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'b1);
    end

    wait_cycles(100);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending events port0=%0d port1=%0d, required 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_game_start.md
# uart_rx_game_start

Serial receiver that replaces the hard-wired game-start signal in the pong top level. It oversamples the board UART RX line, reassembles 8N1 bytes, and raises a one-cycle start strobe for the pong game logic when a configured command byte arrives. The received byte and valid pulse are also exported for other consumers, such as a future score or debug path. It sits directly upstream of the pong game block's game-start input and runs in the single VGA pixel clock domain.

## Interface
Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal range ≥ 4.
- START_CHAR, 8'h53, byte value ('S') that fires o_Game_Start.

Ports:
- i_Clk  input  1  main clock; the only clock in the block.
- i_Reset  input  1  synchronous, active-high reset.
- i_RX_Serial  input  1  asynchronous UART line; idles high.
- o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a newly received, correctly framed byte.
- o_RX_Byte  output  8  last correctly framed byte.
- o_Game_Start  output  1  one-cycle pulse, coincident with o_RX_DV, when the byte equals START_CHAR.
- o_Frame_Error  output  1  one-cycle pulse when the stop bit samples low.

## Operation
- Input synchronizer: 2-flop chain on i_RX_Serial, producing r_RX. Both flops reset to 1.
- Bit counter: width $clog2(CLKS_PER_BIT). Define H = (CLKS_PER_BIT-1)/2 (integer division). Bit index: 3 bits.
- State machine states: IDLE, START, DATA, STOP, CLEANUP, BREAK.
- IDLE:
  - Counter cleared.
  - r_RX==0 → START.
- START:
  - Counter increments.
  - When counter==H, re-check r_RX:
    - 0 → clear counter, bit index=0, go to DATA.
    - 1 → treat as a glitch and return to IDLE with no output activity.
- DATA:
  - When counter==CLKS_PER_BIT-1, sample r_RX into shift-register bit [index] (LSB first) and clear the counter.
  - If index==7, go to STOP; otherwise increment index.
- STOP:
  - When counter==CLKS_PER_BIT-1, sample r_RX:
    - 1 → load o_RX_Byte from the shift register, pulse o_RX_DV, and pulse o_Game_Start if the byte==START_CHAR. Go to CLEANUP.
    - 0 → pulse o_Frame_Error and go to BREAK. o_RX_Byte is unchanged.
- CLEANUP: one cycle with pulses deasserted, then IDLE.
- BREAK: wait until r_RX==1, then go to IDLE. This prevents a held-low line (break) from retriggering reception.
- o_RX_Byte changes only on a good frame and holds its value otherwise.
- o_Game_Start never asserts without o_RX_DV.

## Timing
- Reset values: o_RX_DV=0, o_RX_Byte=8'h00, o_Game_Start=0, o_Frame_Error=0. State=IDLE, counter=0, index=0, shift register=0, sync flops=1.
- Reset is sampled on i_Clk only. Asserting reset mid-frame aborts the frame: no DV, no error, and the next start bit is detected normally after release.
- r_RX lags i_RX_Serial by 2 cycles.
- Let t0 be the first cycle in IDLE with r_RX==0:
  - Start re-check at t0+1+H.
  - Data bit k sampled at t0+1+H+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at t0+1+H+9·CLKS_PER_BIT.
  - o_RX_DV / o_Frame_Error high during cycle t0+2+H+9·CLKS_PER_BIT, for exactly 1 cycle.
- Default parameters give DV 2063 cycles after t0.
- Throughput: back-to-back frames with no idle gap are accepted. CLEANUP plus IDLE detection fit inside the remaining half stop bit. Requires CLKS_PER_BIT ≥ 4.
- Start-bit low pulses shorter than H+1 cycles (as seen on r_RX) are rejected.

## Test plan
- Reset then send 0x53 at 217 clk/bit → o_RX_DV and o_Game_Start both high for 1 cycle at t0+2063; o_RX_Byte=0x53; o_Frame_Error stays 0.
- Send 0xA5 followed immediately by 0x3C with no gap → two DV pulses 2170 cycles apart, bytes 0xA5 then 0x3C; o_Game_Start never asserts.
- 50-cycle low glitch on an idle line → no DV, no error, state back to IDLE; a following 0x53 is received correctly.
- Frame 0x53 with the stop bit driven low, then line held low for 5000 cycles → one o_Frame_Error pulse; no DV and no o_Game_Start; o_RX_Byte keeps its prior value; no further pulses until the line returns high and a valid frame (0x01) is received with DV.
- Assert i_Reset for 1 cycle during data bit 4 of 0x53 → no DV, no error, outputs at reset values; the next full 0x53 frame produces DV and o_Game_Start.
- Parameter override CLKS_PER_BIT=4, START_CHAR=8'h00, send 0x00 → DV and Game_Start at t0+39; send 0xFF → DV only, o_RX_Byte=0xFF.
